mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_starve_ctr.sv | 30 +++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter sequencing states: arbitrate, strobe memory, wait out latency, acknowledge.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_t;

    // Owner codes for the access currently in flight.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Data wins ties unless fetch has been starved for the maximum number of grants.
    function automatic logic pickData(input logic ifReq, input logic dReq, input logic atMax);
        return dReq && !(ifReq && atMax);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants taken while fetch was waiting.
module mem_arb_starve_ctr #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_atMax
);

    localparam int CNT_W = $clog2(MAX_STARVE + 1);
    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_STARVE);

    logic [CNT_W-1:0] r_count;

    // Clear has priority over increment; the count sticks at its maximum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_atMax = (r_count == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and load/store ports.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic [CNT_W-1:0]  r_latCnt;
    logic              r_owner;
    logic              r_memEn;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_ifAck;
    logic              r_dAck;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              w_grant;
    logic              w_pickData;
    logic              w_latDone;
    logic              w_atMax;
    logic              w_starveInc;
    logic              w_starveClr;

    assign w_pickData  = pickData(if_req, d_req, w_atMax);
    assign w_latDone   = (r_state == ARB_WAIT) && (r_latCnt == LAT_LAST);
    assign w_starveInc = w_grant && w_pickData && if_req;
    assign w_starveClr = w_grant && (!w_pickData || !if_req);

    mem_arb_starve_ctr #(
        .MAX_STARVE(MAX_STARVE)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .i_inc  (w_starveInc),
        .i_clr  (w_starveClr),
        .o_atMax(w_atMax)
    );

    // Next-state logic; a grant can only happen while idle.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (if_req || d_req) begin
                    w_grant     = 1'b1;
                    w_nextState = ARB_ISSUE;
                end
            end
            ARB_ISSUE: w_nextState = ARB_WAIT;
            ARB_WAIT:  if (w_latDone) w_nextState = ARB_ACK;
            ARB_ACK:   w_nextState = ARB_IDLE;
            default:   w_nextState = ARB_IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Memory latency counter, restarted from the issue cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latCnt <= '0;
        end else if (r_state == ARB_ISSUE) begin
            r_latCnt <= '0;
        end else if ((r_state == ARB_WAIT) && !w_latDone) begin
            r_latCnt <= r_latCnt + 1'b1;
        end
    end

    // Latch the winner's request at grant; the memory bus holds it until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= OWN_IF;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else if (w_grant) begin
            if (w_pickData) begin
                r_owner    <= OWN_D;
                r_memWe    <= d_we;
                r_memAddr  <= d_addr;
                r_memWdata <= d_wdata;
            end else begin
                r_owner    <= OWN_IF;
                r_memWe    <= 1'b0;
                r_memAddr  <= if_addr;
                r_memWdata <= '0;
            end
        end
    end

    // Registered strobe and ack pulses, derived from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memEn <= 1'b0;
            r_ifAck <= 1'b0;
            r_dAck  <= 1'b0;
        end else begin
            r_memEn <= (w_nextState == ARB_ISSUE);
            r_ifAck <= (w_nextState == ARB_ACK) && (r_owner == OWN_IF);
            r_dAck  <= (w_nextState == ARB_ACK) && (r_owner == OWN_D);
        end
    end

    // Capture read data at the end of the last wait cycle; stores leave d_rdata alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifRdata <= '0;
            r_dRdata  <= '0;
        end else if (w_latDone) begin
            if (r_owner == OWN_IF) begin
                r_ifRdata <= mem_rdata;
            end else if (!r_memWe) begin
                r_dRdata <= mem_rdata;
            end
        end
    end

    assign mem_en    = r_memEn;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign if_ack    = r_ifAck;
    assign d_ack     = r_dAck;
    assign if_rdata  = r_ifRdata;
    assign d_rdata   = r_dRdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;

    typedef struct {
        logic        isData;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
    } vec_t;

    typedef struct {
        logic        isData;
        logic [31:0] rdata;
    } expAck_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;

    // Instance with MEM_LAT=1
    logic        reset, if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // Instance with MEM_LAT=3
    logic        reset3, if_req3, if_ack3, d_req3, d_we3, d_ack3, mem_en3, mem_we3;
    logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    logic [31:0] memArr [logic [31:0]];
    logic [31:0] pipe0, pipe1;
    expAck_t     sbQ[$];
    expAck_t     sbHead;
    vec_t        vecs[7];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_STARVE(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_STARVE(4)) dut3 (
        .clk(clk), .reset(reset3),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // One-cycle synchronous memory behind the MEM_LAT=1 instance.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) memArr[mem_addr] = mem_wdata;
            else        mem_rdata <= memRead(mem_addr);
        end
    end

    // Three-stage read pipeline behind the MEM_LAT=3 instance (read-only pattern memory).
    always @(posedge clk) begin
        pipe0      <= (mem_en3 && !mem_we3) ? (mem_addr3 ^ 32'h5A5A_0000) : 32'h0;
        pipe1      <= pipe0;
        mem_rdata3 <= pipe1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    // Scoreboard: every ack on the MEM_LAT=1 instance must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset && (if_ack || d_ack)) begin
            checkOutput("ack_overlap", 32'(if_ack & d_ack), 32'h0);
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_ack: got if_ack=%0b d_ack=%0b expected none", if_ack, d_ack);
            end else begin
                sbHead = sbQ.pop_front();
                checkOutput("ack_owner", 32'(d_ack), 32'(sbHead.isData));
                checkOutput("ack_rdata", sbHead.isData ? d_rdata : if_rdata, sbHead.rdata);
            end
        end
    end

    // One isolated transaction on the MEM_LAT=1 instance, started in an idle cycle.
    task automatic applyStimulus(input vec_t v);
        int memEnCyc;
        int ackCyc;
        memEnCyc = -1;
        ackCyc   = -1;
        sbQ.push_back('{v.isData, v.expRdata});
        if (v.isData) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= 20 && ackCyc < 0; c++) begin
            @(posedge clk); #1;
            if (mem_en) begin
                memEnCyc = c;
                checkOutput("mem_addr", mem_addr, v.addr);
                checkOutput("mem_we", 32'(mem_we), 32'(v.we));
                if (v.we) checkOutput("mem_wdata", mem_wdata, v.wdata);
            end
            if (if_ack || d_ack) ackCyc = c;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checkOutput("mem_en_cycle", 32'(memEnCyc), 32'd1);
        checkOutput("ack_cycle", 32'(ackCyc), 32'd3);
        @(posedge clk); #1;
        checkOutput("ack_one_cycle", 32'({if_ack, d_ack}), 32'h0);
        checkOutput("rdata_hold", v.isData ? d_rdata : if_rdata, v.expRdata);
    endtask

    // One fetch on the MEM_LAT=3 instance with timing checks.
    task automatic applyLat3(input logic [31:0] addr, input logic [31:0] expRdata);
        int memEnCyc;
        int ackCyc;
        memEnCyc = -1;
        ackCyc   = -1;
        if_req3  = 1'b1;
        if_addr3 = addr;
        for (int c = 1; c <= 20 && ackCyc < 0; c++) begin
            @(posedge clk); #1;
            if (mem_en3) memEnCyc = c;
            if (if_ack3) begin
                ackCyc = c;
                checkOutput("lat3_rdata", if_rdata3, expRdata);
            end
        end
        if_req3 = 1'b0;
        checkOutput("lat3_mem_en_cycle", 32'(memEnCyc), 32'd1);
        checkOutput("lat3_ack_cycle", 32'(ackCyc), 32'd5);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ackCount;
        int lastAck;
        int gotMemEn;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,    32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h1234, 32'hA5A50080};
        vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,    32'h00001234};
        vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,    32'hA5A50044};
        vecs[4] = '{1'b1, 1'b0, 32'h30, 32'h0,    32'hA5A50030};
        vecs[5] = '{1'b1, 1'b1, 32'h30, 32'hCAFE, 32'hA5A50030};
        vecs[6] = '{1'b0, 1'b0, 32'h30, 32'h0,    32'h0000CAFE};
        memArr[32'h10] = 32'hDEADBEEF;

        reset  = 1'b1; reset3 = 1'b1;
        if_req = 1'b1; if_addr = 32'h90; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = 32'h0;
        if_req3 = 1'b0; if_addr3 = 32'h0; d_req3 = 1'b0; d_we3 = 1'b0; d_addr3 = 32'h0; d_wdata3 = 32'h0;

        // Reset held with both requests pending: everything stays quiet.
        gotMemEn = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mem_en) gotMemEn++;
            checkOutput("reset_ctrl_outputs", 32'({mem_en, mem_we, if_ack, d_ack}), 32'h0);
        end
        checkOutput("reset_mem_en_count", 32'(gotMemEn), 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        checkOutput("reset_rdata", if_rdata | d_rdata, 32'h0);

        // Release: data wins the tie on the first grant.
        sbQ.push_back('{1'b1, 32'hA5A50080});
        reset  = 1'b0;
        reset3 = 1'b0;
        @(posedge clk); #1;
        checkOutput("first_grant_mem_en", 32'(mem_en), 32'h1);
        checkOutput("first_grant_addr", mem_addr, 32'h80);
        if_req = 1'b0;
        d_req  = 1'b0;
        for (int c = 0; c < 10 && !d_ack; c++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;

        // Table of isolated single transactions.
        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Both requests held: fetch gets every fifth grant.
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int g = 0; g < 10; g++) begin
            if ((g % 5) == 4) sbQ.push_back('{1'b0, 32'hA5A50100});
            else              sbQ.push_back('{1'b1, 32'hA5A50200});
        end
        ackCount = 0;
        lastAck  = -1;
        for (int c = 1; c <= 100 && ackCount < 10; c++) begin
            @(posedge clk); #1;
            if (if_ack || d_ack) begin
                ackCount++;
                if (lastAck >= 0) checkOutput("ack_period", 32'(c - lastAck), 32'd4);
                lastAck = c;
                if (ackCount == 10) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        checkOutput("starve_ack_count", 32'(ackCount), 32'd10);
        @(posedge clk); #1;

        // Data request dropped during its issue cycle still completes exactly once.
        sbQ.push_back('{1'b1, 32'hA5A50040});
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        @(posedge clk); #1;
        checkOutput("drop_mem_en", 32'(mem_en), 32'h1);
        d_req = 1'b0;
        ackCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (d_ack) ackCount++;
        end
        checkOutput("drop_ack_count", 32'(ackCount), 32'd1);
        applyStimulus('{1'b0, 1'b0, 32'h48, 32'h0, 32'hA5A50048});

        // MEM_LAT=3 timing, then reset in the second wait cycle.
        applyLat3(32'h10, 32'h5A5A0010);
        if_req3 = 1'b1; if_addr3 = 32'h14;
        @(posedge clk); #1;
        checkOutput("lat3_issue", 32'(mem_en3), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset3 = 1'b1;
        #1;
        checkOutput("lat3_async_reset", 32'({mem_en3, if_ack3, d_ack3}), 32'h0);
        if_req3 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset3 = 1'b0;
        ackCount = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (if_ack3 || d_ack3 || mem_en3) ackCount++;
        end
        checkOutput("lat3_abandoned", 32'(ackCount), 32'h0);
        checkOutput("lat3_rdata_cleared", if_rdata3, 32'h0);
        applyLat3(32'h18, 32'h5A5A0018);

        checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
